data_mem_arbiter: RTL

Shares the single byte-lane data memory port (4 rotating byte BRAMs, one command per cycle, 1-cycle synchronous read) between the CPU MEM stage and the VGA scan-out reader. CPU accesses normally win. A wait counter guarantees the VGA reader a slot within a bounded number of cycles. Read data returns in order through a 2-stage owner tag pipeline.

---
 rtl/data_mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Arbitrates the shared byte-lane data memory port between the CPU MEM stage and
// the VGA scan-out reader, with a starvation bound for VGA and in-order read return.
module data_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned ADDR_W       = 18
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [3:0]        cpu_byte_en,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_ack,
   output logic              vga_rvalid,
   output logic [31:0]       vga_rdata,
   output logic [31:0]       mem_addr,
   output logic [4:0]        mem_access_code,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] STARVE_CNT = 4'(STARVE_LIMIT);
   localparam logic [4:0] READ_CODE  = 5'h0F;

   logic [3:0] wait_cnt;
   logic       starve;
   logic       accept_read;
   logic       t1_valid;
   logic       t1_vga;
   logic       t2_valid;
   logic       t2_vga;

   // VGA only beats a requesting CPU once it has been denied STARVE_LIMIT times in a row
   always_comb begin
      starve  = (wait_cnt == STARVE_CNT);
      vga_ack = vga_req & (starve | ~cpu_req);
      cpu_ack = cpu_req & ~vga_ack;
   end

   assign cpu_stall   = cpu_req & ~cpu_ack;
   assign accept_read = vga_ack | (cpu_ack & ~cpu_we);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait_cnt <= 4'd0;
      end else if (vga_ack || !vga_req) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt != STARVE_CNT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Idle edges issue a null code so a stale store is never repeated
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_addr        <= 32'd0;
         mem_access_code <= 5'd0;
         mem_wdata       <= 32'd0;
      end else if (vga_ack) begin
         mem_addr        <= 32'(vga_addr);
         mem_access_code <= READ_CODE;
      end else if (cpu_ack) begin
         mem_addr <= 32'(cpu_addr);
         if (cpu_we) begin
            mem_access_code <= {1'b1, cpu_byte_en};
            mem_wdata       <= cpu_wdata;
         end else begin
            mem_access_code <= READ_CODE;
         end
      end else begin
         mem_access_code <= 5'd0;
      end
   end

   // Owner tags travel alongside the memory's own two-edge read latency
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         t1_valid <= 1'b0;
         t1_vga   <= 1'b0;
         t2_valid <= 1'b0;
         t2_vga   <= 1'b0;
      end else begin
         t1_valid <= accept_read;
         t1_vga   <= vga_ack;
         t2_valid <= t1_valid;
         t2_vga   <= t1_vga;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cpu_rvalid <= 1'b0;
         vga_rvalid <= 1'b0;
         cpu_rdata  <= 32'd0;
         vga_rdata  <= 32'd0;
      end else begin
         cpu_rvalid <= t2_valid & ~t2_vga;
         vga_rvalid <= t2_valid & t2_vga;
         if (t2_valid && !t2_vga) begin
            cpu_rdata <= mem_rdata;
         end
         if (t2_valid && t2_vga) begin
            vga_rdata <= mem_rdata;
         end
      end
   end

endmodule
